// File: rtl/dispatch_ctrl_if.sv
// Purpose: issue-queue head, issue register and execute-stall bundle for dispatch_ctrl.
// Latency: none (wires only).
// Backpressure: ex_stall from execute freezes the issue register; deq_en pops the queue.
// Ports: q_* = two oldest queue entries (slot 0 older), deq_en = pop strobes,
//        iss_* = registered issue slots, ex_stall = execute cannot accept.
interface dispatch_ctrl_if;
    logic [1:0]       q_valid;
    logic [1:0][31:0] q_pc;
    logic [1:0][31:0] q_inst;
    logic [1:0][31:0] q_imm;
    logic [1:0][7:0]  q_aluop;
    logic [1:0][2:0]  q_alusel;
    logic [1:0]       q_wen;
    logic [1:0][4:0]  q_waddr;
    logic [1:0]       q_r1_en;
    logic [1:0]       q_r2_en;
    logic [1:0][4:0]  q_r1_addr;
    logic [1:0][4:0]  q_r2_addr;
    logic [1:0]       deq_en;

    logic [1:0]       iss_valid;
    logic [1:0][31:0] iss_pc;
    logic [1:0][31:0] iss_inst;
    logic [1:0][31:0] iss_imm;
    logic [1:0][7:0]  iss_aluop;
    logic [1:0][2:0]  iss_alusel;
    logic [1:0]       iss_wen;
    logic [1:0][4:0]  iss_waddr;
    logic [1:0]       iss_r1_en;
    logic [1:0]       iss_r2_en;
    logic [1:0][4:0]  iss_r1_addr;
    logic [1:0][4:0]  iss_r2_addr;
    logic             ex_stall;

    // Queue / execute side.
    modport master (
        output q_valid, q_pc, q_inst, q_imm, q_aluop, q_alusel, q_wen, q_waddr,
               q_r1_en, q_r2_en, q_r1_addr, q_r2_addr, ex_stall,
        input  deq_en, iss_valid, iss_pc, iss_inst, iss_imm, iss_aluop, iss_alusel,
               iss_wen, iss_waddr, iss_r1_en, iss_r2_en, iss_r1_addr, iss_r2_addr
    );

    // Dispatch side.
    modport slave (
        input  q_valid, q_pc, q_inst, q_imm, q_aluop, q_alusel, q_wen, q_waddr,
               q_r1_en, q_r2_en, q_r1_addr, q_r2_addr, ex_stall,
        output deq_en, iss_valid, iss_pc, iss_inst, iss_imm, iss_aluop, iss_alusel,
               iss_wen, iss_waddr, iss_r1_en, iss_r2_en, iss_r1_addr, iss_r2_addr
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Purpose: dual-issue dispatch with scoreboard hazards, pair-conflict rules and serialization.
// Latency: 1 cycle from queue head to issue register; deq_en is combinational.
// Backpressure: ex_stall holds the issue register and blocks pops; flush overrides stall.
// Ports: clk, rst (async active-low), flush, wb_clr_en/wb_clr_addr (busy release),
//        serial_done (leaves SERIAL_WAIT), io (queue/issue bundle), pause_dispatch, dual_cnt.
module dispatch_ctrl #(
    parameter logic [2:0] ALUSEL_LOAD   = 3'b100,
    parameter logic [2:0] ALUSEL_STORE  = 3'b101,
    parameter logic [2:0] ALUSEL_MULDIV = 3'b011,
    parameter logic [2:0] ALUSEL_SERIAL = 3'b110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wb_clr_en,
    input  logic [4:0]        wb_clr_addr,
    input  logic              serial_done,
    dispatch_ctrl_if.slave    io,
    output logic              pause_dispatch,
    output logic [15:0]       dual_cnt
);

    typedef enum logic {ST_RUN, ST_SERIAL_WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] busy, busy_set, busy_clr, busy_nxt;
    logic [1:0]  hz, is_ls, is_md, is_serial, issue;
    logic        raw_conflict, pair_conflict, can0, can1;

    // Per-slot hazard and class decode.
    always_comb begin
        hz        = '0;
        is_ls     = '0;
        is_md     = '0;
        is_serial = '0;
        for (int s = 0; s < 2; s++) begin
            hz[s] = (io.q_r1_en[s] && (io.q_r1_addr[s] != 5'd0) && busy[io.q_r1_addr[s]]) ||
                    (io.q_r2_en[s] && (io.q_r2_addr[s] != 5'd0) && busy[io.q_r2_addr[s]]);
            is_ls[s]     = (io.q_alusel[s] == ALUSEL_LOAD) || (io.q_alusel[s] == ALUSEL_STORE);
            is_md[s]     = (io.q_alusel[s] == ALUSEL_MULDIV);
            is_serial[s] = (io.q_alusel[s] == ALUSEL_SERIAL);
        end
    end

    // Slot 1 must not read what slot 0 writes in the same bundle.
    assign raw_conflict  = io.q_wen[0] && (io.q_waddr[0] != 5'd0) &&
                           ((io.q_r1_en[1] && (io.q_r1_addr[1] == io.q_waddr[0])) ||
                            (io.q_r2_en[1] && (io.q_r2_addr[1] == io.q_waddr[0])));
    assign pair_conflict = raw_conflict || (&is_ls) || (|is_serial) || (&is_md);

    assign can0  = io.q_valid[0] && !io.ex_stall && !flush && (state == ST_RUN) && !hz[0];
    assign can1  = can0 && io.q_valid[1] && !hz[1] && !pair_conflict;
    assign issue = {can1, can0};

    assign io.deq_en      = issue;
    assign pause_dispatch = io.q_valid[0] && !can0;

    // Scoreboard: long-latency producers mark their destination busy; a
    // same-cycle set wins over a writeback clear.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        for (int s = 0; s < 2; s++) begin
            if (issue[s] && io.q_wen[s] && (io.q_waddr[s] != 5'd0) &&
                ((io.q_alusel[s] == ALUSEL_LOAD) || is_md[s])) begin
                busy_set[io.q_waddr[s]] = 1'b1;
            end
        end
        if (wb_clr_en) begin
            busy_clr[wb_clr_addr] = 1'b1;
        end
        busy_nxt    = (busy & ~busy_clr) | busy_set;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN:         if ((can0 && is_serial[0]) || (can1 && is_serial[1]))
                                    state_nxt = ST_SERIAL_WAIT;
                ST_SERIAL_WAIT: if (serial_done)
                                    state_nxt = ST_RUN;
                default:        state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       busy <= '0;
        else if (flush) busy <= '0;
        else            busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            dual_cnt <= '0;
        else if (can1 && (dual_cnt != 16'hFFFF)) dual_cnt <= dual_cnt + 16'd1;
    end

    // Issue register: payload of a slot only reloads when that slot issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io.iss_valid   <= '0;
            io.iss_pc      <= '0;
            io.iss_inst    <= '0;
            io.iss_imm     <= '0;
            io.iss_aluop   <= '0;
            io.iss_alusel  <= '0;
            io.iss_wen     <= '0;
            io.iss_waddr   <= '0;
            io.iss_r1_en   <= '0;
            io.iss_r2_en   <= '0;
            io.iss_r1_addr <= '0;
            io.iss_r2_addr <= '0;
        end else if (flush) begin
            io.iss_valid <= '0;
        end else if (!io.ex_stall) begin
            io.iss_valid <= issue;
            for (int s = 0; s < 2; s++) begin
                if (issue[s]) begin
                    io.iss_pc[s]      <= io.q_pc[s];
                    io.iss_inst[s]    <= io.q_inst[s];
                    io.iss_imm[s]     <= io.q_imm[s];
                    io.iss_aluop[s]   <= io.q_aluop[s];
                    io.iss_alusel[s]  <= io.q_alusel[s];
                    io.iss_wen[s]     <= io.q_wen[s];
                    io.iss_waddr[s]   <= io.q_waddr[s];
                    io.iss_r1_en[s]   <= io.q_r1_en[s];
                    io.iss_r2_en[s]   <= io.q_r2_en[s];
                    io.iss_r1_addr[s] <= io.q_r1_addr[s];
                    io.iss_r2_addr[s] <= io.q_r2_addr[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Purpose: directed scenario bench for dispatch_ctrl.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled before the next edge.
// Backpressure: ex_stall and flush are driven explicitly per scenario.
module tb_dispatch_ctrl;
    localparam logic [2:0] ALU    = 3'b000;
    localparam logic [2:0] LOAD   = 3'b100;
    localparam logic [2:0] STORE  = 3'b101;
    localparam logic [2:0] MULDIV = 3'b011;
    localparam logic [2:0] SERIAL = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, wb_clr_en, serial_done, pause_dispatch;
    logic [4:0]  wb_clr_addr;
    logic [15:0] dual_cnt;
    int          checks = 0;
    int          errors = 0;
    int          exp_dual = 0;

    dispatch_ctrl_if io ();

    dispatch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wb_clr_en      (wb_clr_en),
        .wb_clr_addr    (wb_clr_addr),
        .serial_done    (serial_done),
        .io             (io),
        .pause_dispatch (pause_dispatch),
        .dual_cnt       (dual_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        io.q_valid = '0; io.q_pc = '0; io.q_inst = '0; io.q_imm = '0;
        io.q_aluop = '0; io.q_alusel = '0; io.q_wen = '0; io.q_waddr = '0;
        io.q_r1_en = '0; io.q_r2_en = '0; io.q_r1_addr = '0; io.q_r2_addr = '0;
    endtask

    task automatic set_slot(input int s, input logic [2:0] sel, input logic wen,
                            input logic [4:0] wa, input logic r1e, input logic [4:0] r1a,
                            input logic r2e, input logic [4:0] r2a, input logic [31:0] pc);
        io.q_valid[s]   = 1'b1;
        io.q_pc[s]      = pc;
        io.q_inst[s]    = pc ^ 32'hA5A5_0000;
        io.q_imm[s]     = pc + 32'd1;
        io.q_aluop[s]   = pc[7:0];
        io.q_alusel[s]  = sel;
        io.q_wen[s]     = wen;
        io.q_waddr[s]   = wa;
        io.q_r1_en[s]   = r1e;
        io.q_r1_addr[s] = r1a;
        io.q_r2_en[s]   = r2e;
        io.q_r2_addr[s] = r2a;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; wb_clr_en = 1'b0; wb_clr_addr = '0; serial_done = 1'b0;
        io.ex_stall = 1'b0;
        clr_q();
        #12;
        checks++; if (io.iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss_valid: got %b expected 00", io.iss_valid); end
        checks++; if (io.iss_pc[0] !== 32'h0) begin errors++; $display("FAIL reset_iss_pc: got %h expected 0", io.iss_pc[0]); end
        checks++; if (dual_cnt !== 16'h0) begin errors++; $display("FAIL reset_dual_cnt: got %h expected 0", dual_cnt); end
        checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL reset_deq_en: got %b expected 00", io.deq_en); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_dual();
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd3, 1'b1, 5'd1, 1'b0, 5'd0, 32'h100);
        set_slot(1, ALU, 1'b1, 5'd4, 1'b1, 5'd2, 1'b0, 5'd0, 32'h104);
        #1;
        checks++; if (io.deq_en !== 2'b11) begin errors++; $display("FAIL dual_deq_en: got %b expected 11", io.deq_en); end
        checks++; if (pause_dispatch !== 1'b0) begin errors++; $display("FAIL dual_pause: got %b expected 0", pause_dispatch); end
        tick(); exp_dual++;
        clr_q();
        checks++; if (io.iss_valid !== 2'b11) begin errors++; $display("FAIL dual_iss_valid: got %b expected 11", io.iss_valid); end
        checks++; if (io.iss_pc[0] !== 32'h100) begin errors++; $display("FAIL dual_iss_pc0: got %h expected 100", io.iss_pc[0]); end
        checks++; if (io.iss_pc[1] !== 32'h104) begin errors++; $display("FAIL dual_iss_pc1: got %h expected 104", io.iss_pc[1]); end
        checks++; if (io.iss_inst[1] !== 32'hA5A5_0104) begin errors++; $display("FAIL dual_iss_inst1: got %h expected a5a50104", io.iss_inst[1]); end
        checks++; if (io.iss_waddr[1] !== 5'd4) begin errors++; $display("FAIL dual_iss_waddr1: got %0d expected 4", io.iss_waddr[1]); end
        checks++; if (dual_cnt !== 16'd1) begin errors++; $display("FAIL dual_cnt_one: got %0d expected 1", dual_cnt); end
        tick();
        checks++; if (io.iss_valid !== 2'b00) begin errors++; $display("FAIL dual_idle_valid: got %b expected 00", io.iss_valid); end
    endtask

    task automatic test_raw();
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0, 32'h200);
        set_slot(1, ALU, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd5, 32'h204);
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL raw_deq_en: got %b expected 01", io.deq_en); end
        tick();
        checks++; if (io.iss_valid !== 2'b01) begin errors++; $display("FAIL raw_iss_valid: got %b expected 01", io.iss_valid); end
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd5, 32'h204);
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL raw_reader_deq: got %b expected 01", io.deq_en); end
        tick();
        clr_q();
        checks++; if (io.iss_pc[0] !== 32'h204) begin errors++; $display("FAIL raw_reader_pc: got %h expected 204", io.iss_pc[0]); end
        checks++; if (io.iss_r2_addr[0] !== 5'd5) begin errors++; $display("FAIL raw_reader_r2: got %0d expected 5", io.iss_r2_addr[0]); end
        checks++; if (dual_cnt !== 16'(exp_dual)) begin errors++; $display("FAIL raw_dual_cnt: got %0d expected %0d", dual_cnt, exp_dual); end
    endtask

    task automatic test_load_use();
        clr_q();
        set_slot(0, LOAD, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0, 5'd0, 32'h300);
        tick();
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd8, 1'b1, 5'd7, 1'b0, 5'd0, 32'h304);
        #1;
        checks++; if (pause_dispatch !== 1'b1) begin errors++; $display("FAIL lu_pause: got %b expected 1", pause_dispatch); end
        checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL lu_deq_blocked: got %b expected 00", io.deq_en); end
        tick();
        checks++; if (io.iss_valid !== 2'b00) begin errors++; $display("FAIL lu_bubble: got %b expected 00", io.iss_valid); end
        wb_clr_en = 1'b1; wb_clr_addr = 5'd7;
        #1;
        checks++; if (pause_dispatch !== 1'b1) begin errors++; $display("FAIL lu_pause_wb_cycle: got %b expected 1", pause_dispatch); end
        tick();
        wb_clr_en = 1'b0;
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL lu_release_deq: got %b expected 01", io.deq_en); end
        tick();
        checks++; if (io.iss_pc[0] !== 32'h304) begin errors++; $display("FAIL lu_release_pc: got %h expected 304", io.iss_pc[0]); end
        // Set and clear of r14 in the same cycle: the bit must stay set.
        clr_q();
        set_slot(0, LOAD, 1'b1, 5'd14, 1'b0, 5'd0, 1'b0, 5'd0, 32'h320);
        wb_clr_en = 1'b1; wb_clr_addr = 5'd14;
        tick();
        wb_clr_en = 1'b0;
        clr_q();
        set_slot(0, ALU, 1'b0, 5'd0, 1'b1, 5'd14, 1'b0, 5'd0, 32'h324);
        #1;
        checks++; if (pause_dispatch !== 1'b1) begin errors++; $display("FAIL lu_set_wins: got %b expected 1", pause_dispatch); end
        wb_clr_en = 1'b1;
        tick();
        wb_clr_en = 1'b0;
        tick();
        // A store never marks its register busy.
        clr_q();
        set_slot(0, STORE, 1'b1, 5'd15, 1'b0, 5'd0, 1'b0, 5'd0, 32'h330);
        tick();
        clr_q();
        set_slot(0, ALU, 1'b0, 5'd0, 1'b1, 5'd15, 1'b0, 5'd0, 32'h334);
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL lu_store_no_busy: got %b expected 01", io.deq_en); end
        tick();
        clr_q();
    endtask

    task automatic test_conflicts();
        clr_q();
        set_slot(0, LOAD, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h380);
        set_slot(1, STORE, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h384);
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL cf_ldst: got %b expected 01", io.deq_en); end
        io.q_alusel[0] = MULDIV; io.q_alusel[1] = MULDIV;
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL cf_muldiv: got %b expected 01", io.deq_en); end
        io.q_alusel[0] = ALU; io.q_alusel[1] = SERIAL;
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL cf_serial1: got %b expected 01", io.deq_en); end
        io.q_alusel[0] = MULDIV; io.q_alusel[1] = LOAD;
        io.q_wen[0] = 1'b1; io.q_waddr[0] = 5'd0; io.q_r1_en[1] = 1'b1; io.q_r1_addr[1] = 5'd0;
        #1;
        checks++; if (io.deq_en !== 2'b11) begin errors++; $display("FAIL cf_md_ld_r0: got %b expected 11", io.deq_en); end
        io.q_valid = 2'b10;
        #1;
        checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL cf_slot0_empty: got %b expected 00", io.deq_en); end
        clr_q();
        tick();
    endtask

    task automatic test_serial();
        clr_q();
        set_slot(0, SERIAL, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h400);
        set_slot(1, ALU, 1'b1, 5'd3, 1'b1, 5'd1, 1'b0, 5'd0, 32'h404);
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL ser_deq_en: got %b expected 01", io.deq_en); end
        tick();
        checks++; if (io.iss_pc[0] !== 32'h400) begin errors++; $display("FAIL ser_iss_pc: got %h expected 400", io.iss_pc[0]); end
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd3, 1'b1, 5'd1, 1'b0, 5'd0, 32'h404);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL ser_wait_deq[%0d]: got %b expected 00", i, io.deq_en); end
            checks++; if (pause_dispatch !== 1'b1) begin errors++; $display("FAIL ser_wait_pause[%0d]: got %b expected 1", i, pause_dispatch); end
            tick();
        end
        serial_done = 1'b1;
        #1;
        checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL ser_done_cycle: got %b expected 00", io.deq_en); end
        tick();
        serial_done = 1'b0;
        #1;
        checks++; if (io.deq_en !== 2'b01) begin errors++; $display("FAIL ser_resume_deq: got %b expected 01", io.deq_en); end
        tick();
        clr_q();
        checks++; if (io.iss_pc[0] !== 32'h404) begin errors++; $display("FAIL ser_resume_pc: got %h expected 404", io.iss_pc[0]); end
    endtask

    task automatic test_stall_flush();
        clr_q();
        set_slot(0, LOAD, 1'b1, 5'd12, 1'b1, 5'd1, 1'b0, 5'd0, 32'h500);
        set_slot(1, ALU,  1'b1, 5'd13, 1'b1, 5'd2, 1'b0, 5'd0, 32'h504);
        #1;
        checks++; if (io.deq_en !== 2'b11) begin errors++; $display("FAIL st_deq_pre: got %b expected 11", io.deq_en); end
        tick(); exp_dual++;
        io.ex_stall = 1'b1;
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0, 32'h600);
        set_slot(1, ALU, 1'b1, 5'd21, 1'b0, 5'd0, 1'b0, 5'd0, 32'h604);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL st_deq[%0d]: got %b expected 00", i, io.deq_en); end
            tick();
            checks++; if ({io.iss_valid, io.iss_pc[1], io.iss_pc[0]} !== {2'b11, 32'h504, 32'h500})
                begin errors++; $display("FAIL st_hold[%0d]: got %b %h %h expected 11 504 500", i, io.iss_valid, io.iss_pc[1], io.iss_pc[0]); end
        end
        flush = 1'b1;
        #1;
        checks++; if (io.deq_en !== 2'b00) begin errors++; $display("FAIL st_flush_deq: got %b expected 00", io.deq_en); end
        tick();
        flush = 1'b0; io.ex_stall = 1'b0;
        checks++; if (io.iss_valid !== 2'b00) begin errors++; $display("FAIL st_flush_valid: got %b expected 00", io.iss_valid); end
        clr_q();
        set_slot(0, ALU, 1'b1, 5'd3, 1'b1, 5'd12, 1'b0, 5'd0, 32'h510);
        #1;
        checks++; if (pause_dispatch !== 1'b0) begin errors++; $display("FAIL st_busy_cleared: got %b expected 0", pause_dispatch); end
        checks++; if (dual_cnt !== 16'(exp_dual)) begin errors++; $display("FAIL st_dual_kept: got %0d expected %0d", dual_cnt, exp_dual); end
        tick();
        clr_q();
        checks++; if (io.iss_pc[0] !== 32'h510) begin errors++; $display("FAIL st_after_pc: got %h expected 510", io.iss_pc[0]); end
    endtask

    task automatic test_reset_serial();
        clr_q();
        set_slot(0, LOAD, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h700);
        tick();
        clr_q();
        set_slot(0, SERIAL, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h704);
        tick();
        clr_q();
        io.ex_stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (io.iss_valid !== 2'b00) begin errors++; $display("FAIL rs_iss_valid: got %b expected 00", io.iss_valid); end
        checks++; if (io.iss_pc[0] !== 32'h0) begin errors++; $display("FAIL rs_iss_pc: got %h expected 0", io.iss_pc[0]); end
        checks++; if (dual_cnt !== 16'h0) begin errors++; $display("FAIL rs_dual_cnt: got %0d expected 0", dual_cnt); end
        checks++; if ({io.deq_en, pause_dispatch} !== 3'b000) begin errors++; $display("FAIL rs_comb_outs: got %b expected 000", {io.deq_en, pause_dispatch}); end
        @(negedge clk);
        rst = 1'b1;
        io.ex_stall = 1'b0;
        set_slot(0, ALU, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd9, 32'h710);
        #1;
        checks++; if ({io.deq_en, pause_dispatch} !== 3'b010) begin errors++; $display("FAIL rs_r9_reader: got %b expected 010", {io.deq_en, pause_dispatch}); end
        tick();
        clr_q();
        checks++; if (io.iss_pc[0] !== 32'h710) begin errors++; $display("FAIL rs_r9_issued: got %h expected 710", io.iss_pc[0]); end
    endtask

    initial begin
        test_reset();
        test_dual();
        test_raw();
        test_load_use();
        test_conflicts();
        test_serial();
        test_stall_flush();
        test_reset_serial();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound the run in case a scenario never returns.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter: ALUSEL_LOAD, 3'b100, load class code.
REQ-002 Parameter: ALUSEL_STORE, 3'b101, store class code.
REQ-003 Parameter: ALUSEL_MULDIV, 3'b011, long-latency arithmetic class code.
REQ-004 Parameter: ALUSEL_SERIAL, 3'b110, CSR/privileged serializing class code.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- flush, in, 1, synchronous pipeline flush.
- q_valid, in, [1:0], queue head entries valid; slot 0 is older.
- q_pc / q_inst / q_imm, in, [1:0][31:0], payload.
- q_aluop, in, [1:0][7:0], payload.
- q_alusel, in, [1:0][2:0], payload.
- q_wen, in, [1:0], destination write enable.
- q_waddr, in, [1:0][4:0], destination register.
- q_r1_en / q_r2_en, in, [1:0], source read enables.
- q_r1_addr / q_r2_addr, in, [1:0][4:0], source registers.
- ex_stall, in, 1, execute stage cannot accept.
- wb_clr_en, in, 1, long-latency result written back.
- wb_clr_addr, in, 5, register released by writeback.
- serial_done, in, 1, serializing instruction committed.
- deq_en, out, [1:0], pop strobes to the queue (invalid_en).
- iss_valid, out, [1:0], issue register valid.
- iss_*, out, same widths as q_*, registered payload for every q_* field.
- pause_dispatch, out, 1, no slot issued while q_valid[0]=1.
- dual_cnt, out, 16, saturating count of dual-issue cycles.

Function
REQ-006 hz(s): slot s reads (en=1) a register whose busy bit is set and whose address is nonzero.
REQ-007 can0 = q_valid[0] & !ex_stall & !flush & state==RUN & !hz(0).
REQ-008 can1 = can0 & q_valid[1] & !hz(1) & no conflict; each condition below is a conflict:
- slot 0 writes (wen=1, addr!=0) a register that slot 1 reads;
- both slots are load/store class;
- either slot is ALUSEL_SERIAL;
- both slots are ALUSEL_MULDIV.
REQ-009 deq_en = {can1, can0}, combinational in the same cycle; deq_en[1] never asserts without deq_en[0].
REQ-010 On a clock edge with !ex_stall: iss_valid <= {can1, can0}, and each iss_* slot loads its q_* payload when issued. Latency is 1 cycle.
REQ-011 On a clock edge with ex_stall=1: iss_valid and iss_* hold their values.
REQ-012 Busy table: 32 bits. An issued slot of class LOAD or MULDIV with wen=1 and waddr!=0 sets busy[waddr] at the edge.
REQ-013 wb_clr_en=1 clears busy[wb_clr_addr] at the edge. A set and a clear of the same register in the same cycle leaves the bit set. busy[0] is always 0.
REQ-014 FSM states:
- RUN -> SERIAL_WAIT when an ALUSEL_SERIAL instruction issues.
- SERIAL_WAIT -> RUN on serial_done=1. No issue occurs in SERIAL_WAIT.
REQ-015 flush=1 at an edge does all of the following:
- clears iss_valid and the busy table;
- forces state to RUN;
- holds deq_en at 0 in that cycle.
flush has priority over ex_stall.
REQ-016 pause_dispatch = q_valid[0] & !can0.
REQ-017 dual_cnt increments when can1=1 and saturates at 16'hFFFF; flush does not clear it.

Reset
REQ-018 While rst=0, asynchronously: iss_valid=0, iss_* payload=0, busy table=0, state=RUN, dual_cnt=0.
REQ-019 Reset asserted mid-stall or in SERIAL_WAIT returns the block to RUN. After rst deasserts, first issue is possible in the next cycle.

Verification
REQ-020 Independent ALU pair (r1->r3, r2->r4), no stall -> deq_en=2'b11, iss_valid=2'b11 next cycle, dual_cnt=1.
REQ-021 Slot 0 writes r5, slot 1 reads r5 -> deq_en=2'b01; next cycle the r5 reader is at slot 0 and issues alone.
REQ-022 Load to r7 issues; next instruction reads r7 -> pause_dispatch=1 until a cycle with wb_clr_en=1, wb_clr_addr=7; issue occurs in the following cycle.
REQ-023 CSR instruction issues -> SERIAL_WAIT, deq_en=0 for 3 cycles; serial_done pulse -> RUN, next instruction issues.
REQ-024 ex_stall held 2 cycles with iss_valid=2'b11 -> iss_* unchanged and deq_en=0. A flush during the stall -> iss_valid=0 and busy table cleared.
REQ-025 rst pulled low in SERIAL_WAIT with busy[9]=1 -> all outputs 0 immediately; after release, a reader of r9 issues without stall.
